// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEMACC/WB with a shared mult/div busy timer.
// Strobes are combinational from state and Instr; the next state is registered on every clk edge.
module mc_controller #(
    parameter int MEM_LAT  = 1,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        cmp_true,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic [2:0]  Mem2Reg,
    output logic [2:0]  ALUControl,
    output logic        ALUSrc,
    output logic [2:0]  EXTControl,
    output logic [4:0]  RegAddr,
    output logic [2:0]  NPCControl,
    output logic        md_start,
    output logic        md_busy,
    output logic [2:0]  state
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEMACC = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam int              BW        = $clog2(DIV_CYC + 1);
    localparam logic [3:0]      WAIT_LAST = 4'(MEM_LAT - 1);
    localparam logic [BW-1:0]   MULT_LOAD = BW'(MULT_CYC);
    localparam logic [BW-1:0]   DIV_LOAD  = BW'(DIV_CYC);
    localparam logic [BW-1:0]   BUSY_ONE  = BW'(1);

    logic [2:0]    r_state;
    logic [3:0]    r_wait;
    logic [BW-1:0] r_busy;

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rt;
    logic [4:0] w_rd;
    logic       w_unused;

    assign w_op     = Instr[31:26];
    assign w_fn     = Instr[5:0];
    assign w_rt     = Instr[20:16];
    assign w_rd     = Instr[15:11];
    assign w_unused = ^{Instr[25:21], Instr[10:6]};

    logic w_rtype;
    logic w_add, w_sub, w_xor, w_sll, w_jr, w_jalr, w_mult, w_div, w_mfhi, w_mflo;
    logic w_ori, w_addi, w_lui, w_lw, w_lb, w_sw, w_beq, w_bgtz, w_j, w_jal;

    assign w_rtype = (w_op == 6'h00);
    assign w_add   = w_rtype && (w_fn == 6'h20);
    assign w_sub   = w_rtype && (w_fn == 6'h22);
    assign w_xor   = w_rtype && (w_fn == 6'h26);
    assign w_sll   = w_rtype && (w_fn == 6'h00);
    assign w_jr    = w_rtype && (w_fn == 6'h08);
    assign w_jalr  = w_rtype && (w_fn == 6'h09);
    assign w_mult  = w_rtype && (w_fn == 6'h18);
    assign w_div   = w_rtype && (w_fn == 6'h1A);
    assign w_mfhi  = w_rtype && (w_fn == 6'h10);
    assign w_mflo  = w_rtype && (w_fn == 6'h12);
    assign w_ori   = (w_op == 6'h0D);
    assign w_addi  = (w_op == 6'h08);
    assign w_lui   = (w_op == 6'h0F);
    assign w_lw    = (w_op == 6'h23);
    assign w_lb    = (w_op == 6'h20);
    assign w_sw    = (w_op == 6'h2B);
    assign w_beq   = (w_op == 6'h04);
    assign w_bgtz  = (w_op == 6'h07);
    assign w_j     = (w_op == 6'h02);
    assign w_jal   = (w_op == 6'h03);

    logic w_alu_wr, w_rd_wr, w_rt_wr, w_mem, w_br, w_jmp, w_link, w_md, w_mf;

    assign w_rd_wr  = w_add | w_sub | w_xor | w_sll | w_jalr | w_mfhi | w_mflo;
    assign w_rt_wr  = w_ori | w_addi | w_lui | w_lw | w_lb;
    assign w_alu_wr = w_add | w_sub | w_xor | w_sll | w_ori | w_addi | w_lui;
    assign w_mem    = w_lw | w_lb | w_sw;
    assign w_br     = w_beq | w_bgtz;
    assign w_jmp    = w_j | w_jr;
    assign w_link   = w_jal | w_jalr;
    assign w_md     = w_mult | w_div;
    assign w_mf     = w_mfhi | w_mflo;

    logic [2:0] w_npc;

    always_comb begin
        ALUControl = 3'd0;
        if (w_sub)      ALUControl = 3'd1;
        else if (w_xor) ALUControl = 3'd2;
        else if (w_ori) ALUControl = 3'd3;
        else if (w_sll) ALUControl = 3'd4;

        Mem2Reg = 3'd0;
        if (w_lw)                Mem2Reg = 3'd1;
        else if (w_lui)          Mem2Reg = 3'd2;
        else if (w_link)         Mem2Reg = 3'd3;
        else if (w_lb)           Mem2Reg = 3'd4;
        else if (w_mfhi)         Mem2Reg = 3'd5;
        else if (w_mflo)         Mem2Reg = 3'd6;

        EXTControl = 3'd0;
        if (w_lw | w_lb | w_sw | w_beq | w_bgtz | w_addi) EXTControl = 3'd1;
        else if (w_lui)                                  EXTControl = 3'd2;

        w_npc = 3'd0;
        if (w_br)        w_npc = 3'd1;
        else if (w_j | w_jal)  w_npc = 3'd2;
        else if (w_jr | w_jalr) w_npc = 3'd4;

        RegAddr = 5'd0;
        if (w_rd_wr)      RegAddr = w_rd;
        else if (w_rt_wr) RegAddr = w_rt;
        else if (w_jal)   RegAddr = 5'd31;
    end

    assign ALUSrc = w_ori | w_addi | w_lui | w_lw | w_lb | w_sw;

    logic       w_last;
    logic       w_md_busy;
    logic [2:0] w_next;
    logic       w_pcw, w_irw, w_memw, w_regw, w_mds;

    assign w_last    = (r_wait == WAIT_LAST);
    assign w_md_busy = (r_busy != '0);

    always_comb begin
        w_next = r_state;
        w_pcw  = 1'b0;
        w_irw  = 1'b0;
        w_memw = 1'b0;
        w_regw = 1'b0;
        w_mds  = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_last) begin
                    w_pcw  = 1'b1;
                    w_irw  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                // HI/LO consumers and new launches both wait for the unit to drain
                if ((w_md | w_mf) && w_md_busy) begin
                    w_next = S_EXEC;
                end else if (w_md) begin
                    w_mds  = 1'b1;
                    w_next = S_FETCH;
                end else if (w_mf || w_alu_wr) begin
                    w_next = S_WB;
                end else if (w_mem) begin
                    w_next = S_MEMACC;
                end else if (w_br) begin
                    w_pcw  = cmp_true;
                    w_next = S_FETCH;
                end else if (w_jmp) begin
                    w_pcw  = 1'b1;
                    w_next = S_FETCH;
                end else if (w_link) begin
                    w_pcw  = 1'b1;
                    w_next = S_WB;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMACC: begin
                if (w_last) begin
                    w_memw = w_sw;
                    w_next = w_sw ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                w_regw = 1'b1;
                w_next = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Gating with reset keeps FETCH's last-cycle strobes from firing while held in reset.
    assign PCWrite    = w_pcw  & ~reset;
    assign IRWrite    = w_irw  & ~reset;
    assign MemWrite   = w_memw & ~reset;
    assign RegWrite   = w_regw & ~reset;
    assign md_start   = w_mds  & ~reset;
    assign md_busy    = w_md_busy;
    assign NPCControl = (r_state == S_FETCH) ? 3'd0 : w_npc;
    assign state      = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_wait  <= 4'd0;
            r_busy  <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                r_wait <= 4'd0;
            end else if (r_state == S_FETCH || r_state == S_MEMACC) begin
                r_wait <= r_wait + 4'd1;
            end else begin
                r_wait <= 4'd0;
            end

            if (w_mds) begin
                r_busy <= w_div ? DIV_LOAD : MULT_LOAD;
            end else if (w_md_busy) begin
                r_busy <= r_busy - BUSY_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: two instances (MEM_LAT=1 and MEM_LAT=3) checked against a per-cycle trace model.
module tb_mc_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, rst3;
    logic [31:0] Instr;
    logic        cmp_true;

    logic       pcw[2], irw[2], mw[2], rw[2], mds[2], mdb[2], src[2];
    logic [2:0] m2r[2], alu[2], ext[2], npc[2], st[2];
    logic [4:0] ra[2];

    mc_controller #(.MEM_LAT(1), .MULT_CYC(5), .DIV_CYC(10)) u_ml1 (
        .clk(clk), .reset(rst1), .Instr(Instr), .cmp_true(cmp_true),
        .PCWrite(pcw[0]), .IRWrite(irw[0]), .MemWrite(mw[0]), .RegWrite(rw[0]),
        .Mem2Reg(m2r[0]), .ALUControl(alu[0]), .ALUSrc(src[0]), .EXTControl(ext[0]),
        .RegAddr(ra[0]), .NPCControl(npc[0]), .md_start(mds[0]), .md_busy(mdb[0]),
        .state(st[0])
    );

    mc_controller #(.MEM_LAT(3), .MULT_CYC(5), .DIV_CYC(10)) u_ml3 (
        .clk(clk), .reset(rst3), .Instr(Instr), .cmp_true(cmp_true),
        .PCWrite(pcw[1]), .IRWrite(irw[1]), .MemWrite(mw[1]), .RegWrite(rw[1]),
        .Mem2Reg(m2r[1]), .ALUControl(alu[1]), .ALUSrc(src[1]), .EXTControl(ext[1]),
        .RegAddr(ra[1]), .NPCControl(npc[1]), .md_start(mds[1]), .md_busy(mdb[1]),
        .state(st[1])
    );

    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_J = 4;
    localparam int K_JL = 5, K_MD = 6, K_MF = 7, K_NOP = 8;

    typedef struct {
        logic [31:0] w;
        bit          c;
        int          kind, cyc, alu, m2r, ext, npc, ra;
        bit          src;
    } vec_t;

    typedef struct {
        int   st;
        bit   pcw, irw, mw, rw, mds, busy, lastf;
        vec_t v;
    } exp_t;

    exp_t q[$];
    exp_t ce;
    int   ml     = 1;
    int   mbusy  = 0;
    int   sel    = 0;
    int   checks = 0;
    int   errors = 0;
    int   mds_cnt = 0;

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, expv, $time);
        end
    endtask

    function automatic vec_t V(input logic [31:0] w, input bit c, input int kind, input int cyc,
                               input int alu_e, input int m2r_e, input int ext_e,
                               input int npc_e, input int ra_e, input bit src_e);
        vec_t r;
        r.w = w; r.c = c; r.kind = kind; r.cyc = cyc; r.alu = alu_e; r.m2r = m2r_e;
        r.ext = ext_e; r.npc = npc_e; r.ra = ra_e; r.src = src_e;
        return r;
    endfunction

    // One expected cycle; the busy timer counts down once per cycle regardless of state.
    task automatic push(input int s, input bit pcw_e, input bit irw_e, input bit mw_e,
                        input bit rw_e, input bit mds_e, input bit lastf, input vec_t v);
        exp_t e;
        e.st = s; e.pcw = pcw_e; e.irw = irw_e; e.mw = mw_e; e.rw = rw_e;
        e.mds = mds_e; e.busy = (mbusy != 0); e.lastf = lastf; e.v = v;
        q.push_back(e);
        if (mds_e)          mbusy = v.cyc;
        else if (mbusy > 0) mbusy--;
    endtask

    task automatic expand(input vec_t v);
        for (int i = 0; i < ml; i++) push(0, i == ml-1, i == ml-1, 0, 0, 0, i == ml-1, v);
        push(1, 0, 0, 0, 0, 0, 0, v);
        case (v.kind)
            K_ALU: begin push(2, 0, 0, 0, 0, 0, 0, v); push(4, 0, 0, 0, 1, 0, 0, v); end
            K_LD: begin
                push(2, 0, 0, 0, 0, 0, 0, v);
                for (int i = 0; i < ml; i++) push(3, 0, 0, 0, 0, 0, 0, v);
                push(4, 0, 0, 0, 1, 0, 0, v);
            end
            K_ST: begin
                push(2, 0, 0, 0, 0, 0, 0, v);
                for (int i = 0; i < ml; i++) push(3, 0, 0, i == ml-1, 0, 0, 0, v);
            end
            K_BR:  push(2, v.c, 0, 0, 0, 0, 0, v);
            K_J:   push(2, 1, 0, 0, 0, 0, 0, v);
            K_JL:  begin push(2, 1, 0, 0, 0, 0, 0, v); push(4, 0, 0, 0, 1, 0, 0, v); end
            K_MD: begin
                while (mbusy > 0) push(2, 0, 0, 0, 0, 0, 0, v);
                push(2, 0, 0, 0, 0, 1, 0, v);
            end
            K_MF: begin
                while (mbusy > 0) push(2, 0, 0, 0, 0, 0, 0, v);
                push(2, 0, 0, 0, 0, 0, 0, v);
                push(4, 0, 0, 0, 1, 0, 0, v);
            end
            default: push(2, 0, 0, 0, 0, 0, 0, v);
        endcase
    endtask

    task automatic issue(input vec_t v, output int n);
        int s;
        Instr    = v.w;
        cmp_true = v.c;
        s = q.size();
        expand(v);
        n = q.size() - s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            ce = q.pop_front();
            chk("state",    st[sel],  ce.st);
            chk("PCWrite",  pcw[sel], ce.pcw);
            chk("IRWrite",  irw[sel], ce.irw);
            chk("MemWrite", mw[sel],  ce.mw);
            chk("RegWrite", rw[sel],  ce.rw);
            chk("md_start", mds[sel], ce.mds);
            chk("md_busy",  mdb[sel], ce.busy);
            if (ce.lastf) chk("npc_fetch", npc[sel], 0);
            if (ce.st == 2) begin
                chk("NPCControl", npc[sel], ce.v.npc);
                chk("ALUControl", alu[sel], ce.v.alu);
                chk("EXTControl", ext[sel], ce.v.ext);
                chk("ALUSrc",     src[sel], ce.v.src);
            end
            if (ce.st == 2 || ce.st == 4) begin
                chk("RegAddr", ra[sel],  ce.v.ra);
                chk("Mem2Reg", m2r[sel], ce.v.m2r);
            end
        end
    end

    always @(negedge clk) if (mds[sel]) mds_cnt++;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c0;
        rst1 = 1'b1; rst3 = 1'b1; Instr = 32'h0; cmp_true = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state",   st[0],  0);
        chk("rst_md_busy", mdb[0], 0);
        chk("rst_IRWrite", irw[0], 0);
        chk("rst_PCWrite", pcw[0], 0);

        sel = 0; ml = 1; mbusy = 0; rst1 = 1'b0;
        issue(V(32'h00221820, 0, K_ALU, 0, 0, 0, 0, 0, 3,  0), n); chk("len_add", n, 4);
        issue(V(32'h00222022, 0, K_ALU, 0, 1, 0, 0, 0, 4,  0), n);
        issue(V(32'h00226026, 0, K_ALU, 0, 2, 0, 0, 0, 12, 0), n);
        issue(V(32'h00026880, 0, K_ALU, 0, 4, 0, 0, 0, 13, 0), n);
        issue(V(32'h342500FF, 0, K_ALU, 0, 3, 0, 0, 0, 5,  1), n);
        issue(V(32'h202EFFFF, 0, K_ALU, 0, 0, 0, 1, 0, 14, 1), n);
        issue(V(32'h3C0B1234, 0, K_ALU, 0, 0, 2, 2, 0, 11, 1), n);
        issue(V(32'h8C260004, 0, K_LD,  0, 0, 1, 1, 0, 6,  1), n); chk("len_lw", n, 5);
        issue(V(32'h802A0001, 0, K_LD,  0, 0, 4, 1, 0, 10, 1), n);
        issue(V(32'hAC220008, 0, K_ST,  0, 0, 0, 1, 0, 0,  1), n); chk("len_sw1", n, 4);
        issue(V(32'h10220003, 0, K_BR,  0, 0, 0, 1, 1, 0,  0), n); chk("len_beq", n, 3);
        issue(V(32'h10220003, 1, K_BR,  0, 0, 0, 1, 1, 0,  0), n);
        issue(V(32'h1C200002, 1, K_BR,  0, 0, 0, 1, 1, 0,  0), n);
        issue(V(32'h08000040, 0, K_J,   0, 0, 0, 0, 2, 0,  0), n);
        issue(V(32'h0C000010, 0, K_JL,  0, 0, 3, 0, 2, 31, 0), n);
        issue(V(32'h03E00008, 0, K_J,   0, 0, 0, 0, 4, 0,  0), n);
        issue(V(32'h00204809, 0, K_JL,  0, 0, 3, 0, 4, 9,  0), n);
        issue(V(32'h00220018, 0, K_MD,  5, 0, 0, 0, 0, 0,  0), n);
        issue(V(32'h00004010, 0, K_MF,  0, 0, 5, 0, 0, 8,  0), n); chk("len_mfhi", n, 7);
        c0 = mds_cnt;
        issue(V(32'h0022001A, 0, K_MD, 10, 0, 0, 0, 0, 0,  0), n); chk("len_div", n, 3);
        issue(V(32'h00003812, 0, K_MF,  0, 0, 6, 0, 0, 7,  0), n); chk("len_mflo", n, 12);
        chk("md_start_pulses", mds_cnt - c0, 1);
        issue(V(32'hFC000000, 0, K_NOP, 0, 0, 0, 0, 0, 0,  0), n); chk("len_undef", n, 3);
        issue(V(32'h00221820, 0, K_ALU, 0, 0, 0, 0, 0, 3,  0), n);

        rst1 = 1'b1; sel = 1; ml = 3; mbusy = 0; rst3 = 1'b0;
        issue(V(32'hAC220008, 0, K_ST,  0, 0, 0, 1, 0, 0,  1), n); chk("len_sw3", n, 8);
        issue(V(32'h8C260004, 0, K_LD,  0, 0, 1, 1, 0, 6,  1), n); chk("len_lw3", n, 9);
        issue(V(32'h0022001A, 0, K_MD, 10, 0, 0, 0, 0, 0,  0), n);

        // sw with reset dropped into the second MEMACC cycle while the divider is still busy
        Instr = 32'hAC220008; cmp_true = 1'b0;
        expand(V(32'hAC220008, 0, K_ST, 0, 0, 0, 1, 0, 0, 1));
        repeat (6) @(posedge clk);
        #1;
        chk("pre_rst_state",   st[1],  3);
        chk("pre_rst_md_busy", mdb[1], 1);
        q.delete();
        #2 rst3 = 1'b1;
        #1;
        chk("async_state",    st[1],  0);
        chk("async_md_busy",  mdb[1], 0);
        chk("async_MemWrite", mw[1],  0);
        chk("async_strobes",  {pcw[1], irw[1], rw[1], mds[1]}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("held_state",    st[1], 0);
        chk("held_MemWrite", mw[1], 0);
        mbusy = 0; rst3 = 1'b0;
        issue(V(32'h00221820, 0, K_ALU, 0, 0, 0, 0, 0, 3, 0), n); chk("len_add3", n, 6);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
